// File: rtl/mlp_loader.sv
// Framed byte-stream loader assembling the mlp core's weight, bias and input arrays.
// Array bytes are visible one cycle after acceptance; s_ready_o drops only while in ERR until clear_i.
module mlp_loader (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [7:0]              s_data_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   input  logic                    clear_i,
   output logic [5:0][15:0][7:0]   w1_o,
   output logic [15:0][7:0]        b1_o,
   output logic [15:0][2:0][7:0]   w2_o,
   output logic [2:0][7:0]         b2_o,
   output logic [5:0][7:0]         din_o,
   output logic                    params_valid_o,
   output logic                    din_valid_o,
   output logic                    start_o,
   output logic                    busy_o,
   output logic                    err_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD_P = 2'd1,
      ST_LOAD_D = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

   localparam logic [7:0] OP_PARAMS = 8'h01;
   localparam logic [7:0] OP_DIN    = 8'h02;
   localparam logic [7:0] P_LAST    = 8'd162;
   localparam logic [7:0] D_LAST    = 8'd5;

   state_t              r_state;
   logic [7:0]          r_cnt;
   logic [162:0][7:0]   r_par;
   logic [5:0][7:0]     r_din;
   logic                r_pv;
   logic                r_dv;
   logic                r_start;
   logic                r_err;

   state_t              w_state_nxt;
   logic [7:0]          w_cnt_nxt;
   logic                w_pv_nxt;
   logic                w_dv_nxt;
   logic                w_start_nxt;
   logic                w_err_nxt;
   logic                w_wr_p;
   logic                w_wr_d;
   logic                w_acc;

   assign w_acc = s_valid_i && (r_state != ST_ERR);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pv_nxt    = r_pv;
      w_dv_nxt    = r_dv;
      w_start_nxt = 1'b0;
      w_err_nxt   = r_err;
      w_wr_p      = 1'b0;
      w_wr_d      = 1'b0;
      if (clear_i) begin
         // abort wins over any byte handshaked in the same cycle
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = 8'd0;
         w_err_nxt   = 1'b0;
      end else if (w_acc) begin
         case (r_state)
            ST_IDLE: begin
               w_cnt_nxt = 8'd0;
               if (s_data_i == OP_PARAMS) begin
                  w_state_nxt = ST_LOAD_P;
                  w_pv_nxt    = 1'b0;
               end else if (s_data_i == OP_DIN) begin
                  w_state_nxt = ST_LOAD_D;
                  w_dv_nxt    = 1'b0;
               end else begin
                  w_state_nxt = ST_ERR;
                  w_err_nxt   = 1'b1;
               end
            end
            ST_LOAD_P: begin
               w_wr_p = 1'b1;
               if (r_cnt == P_LAST) begin
                  w_pv_nxt    = 1'b1;
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
            ST_LOAD_D: begin
               w_wr_d = 1'b1;
               if (r_cnt == D_LAST) begin
                  w_dv_nxt    = 1'b1;
                  w_start_nxt = r_pv;
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
         r_par   <= '0;
         r_din   <= '0;
         r_pv    <= 1'b0;
         r_dv    <= 1'b0;
         r_start <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pv    <= w_pv_nxt;
         r_dv    <= w_dv_nxt;
         r_start <= w_start_nxt;
         r_err   <= w_err_nxt;
         if (w_wr_p) r_par[r_cnt] <= s_data_i;
         if (w_wr_d) r_din[r_cnt[2:0]] <= s_data_i;
      end
   end

   // Payload byte k lands in r_par[k]; the packed output arrays are laid out
   // row-major so each is a contiguous slice of that image.
   assign w1_o           = r_par[95:0];
   assign b1_o           = r_par[111:96];
   assign w2_o           = r_par[159:112];
   assign b2_o           = r_par[162:160];
   assign din_o          = r_din;
   assign params_valid_o = r_pv;
   assign din_valid_o    = r_dv;
   assign start_o        = r_start;
   assign err_o          = r_err;
   assign s_ready_o      = (r_state != ST_ERR);
   assign busy_o         = (r_state == ST_LOAD_P) || (r_state == ST_LOAD_D);

endmodule

// File: tb/tb_mlp_loader.sv
// Bench for mlp_loader: directed frames checked against a byte-image reference model every cycle.
module tb_mlp_loader;

   logic                  clk_i;
   logic                  rst_i;
   logic [7:0]            s_data_i;
   logic                  s_valid_i;
   logic                  s_ready_o;
   logic                  clear_i;
   logic [5:0][15:0][7:0] w1_o;
   logic [15:0][7:0]      b1_o;
   logic [15:0][2:0][7:0] w2_o;
   logic [2:0][7:0]       b2_o;
   logic [5:0][7:0]       din_o;
   logic                  params_valid_o;
   logic                  din_valid_o;
   logic                  start_o;
   logic                  busy_o;
   logic                  err_o;

   int checks = 0;
   int errors = 0;
   int start_seen = 0;

   mlp_loader dut (
      .clk_i(clk_i), .rst_i(rst_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
      .s_ready_o(s_ready_o), .clear_i(clear_i), .w1_o(w1_o), .b1_o(b1_o),
      .w2_o(w2_o), .b2_o(b2_o), .din_o(din_o), .params_valid_o(params_valid_o),
      .din_valid_o(din_valid_o), .start_o(start_o), .busy_o(busy_o), .err_o(err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: the parameter stream as a flat byte image plus a frame mode.
   localparam int M_IDLE = 0;
   localparam int M_PAR  = 1;
   localparam int M_DIN  = 2;
   localparam int M_ERR  = 3;

   int         m_mode;
   logic [7:0] m_pos;
   logic [7:0] m_par [0:162];
   logic [7:0] m_din [0:5];
   logic       m_pv, m_dv, m_start, m_err;

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_mode  <= M_IDLE;
         m_pos   <= 8'd0;
         m_par   <= '{default: 8'h00};
         m_din   <= '{default: 8'h00};
         m_pv    <= 1'b0;
         m_dv    <= 1'b0;
         m_start <= 1'b0;
         m_err   <= 1'b0;
      end else begin
         m_start <= 1'b0;
         if (clear_i) begin
            m_mode <= M_IDLE;
            m_pos  <= 8'd0;
            m_err  <= 1'b0;
         end else if (s_valid_i && m_mode != M_ERR) begin
            case (m_mode)
               M_IDLE: begin
                  m_pos <= 8'd0;
                  if (s_data_i == 8'h01) begin m_mode <= M_PAR; m_pv <= 1'b0; end
                  else if (s_data_i == 8'h02) begin m_mode <= M_DIN; m_dv <= 1'b0; end
                  else begin m_mode <= M_ERR; m_err <= 1'b1; end
               end
               M_PAR: begin
                  m_par[m_pos] <= s_data_i;
                  if (m_pos == 8'd162) begin m_pv <= 1'b1; m_mode <= M_IDLE; end
                  else m_pos <= m_pos + 8'd1;
               end
               M_DIN: begin
                  m_din[m_pos[2:0]] <= s_data_i;
                  if (m_pos == 8'd5) begin m_dv <= 1'b1; m_start <= m_pv; m_mode <= M_IDLE; end
                  else m_pos <= m_pos + 8'd1;
               end
               default: ;
            endcase
         end
      end
   end

   function automatic logic [7:0] act_byte(input int k);
      if (k < 96)       return w1_o[3'(k / 16)][4'(k % 16)];
      else if (k < 112) return b1_o[4'(k - 96)];
      else if (k < 160) return w2_o[4'((k - 112) / 3)][2'((k - 112) % 3)];
      else              return b2_o[2'(k - 160)];
   endfunction

   always @(negedge clk_i) begin
      if (!rst_i) begin
         int bad;
         check("s_ready", 32'(s_ready_o), 32'(m_mode != M_ERR));
         check("busy", 32'(busy_o), 32'(m_mode == M_PAR || m_mode == M_DIN));
         check("params_valid", 32'(params_valid_o), 32'(m_pv));
         check("din_valid", 32'(din_valid_o), 32'(m_dv));
         check("start", 32'(start_o), 32'(m_start));
         check("err", 32'(err_o), 32'(m_err));
         bad = -1;
         for (int k = 0; k < 163; k++)
            if (bad < 0 && act_byte(k) !== m_par[8'(k)]) bad = k;
         checks++;
         if (bad >= 0) begin
            errors++;
            $display("FAIL param_image k=%0d at %0t: got %0h expected %0h",
                     bad, $time, act_byte(bad), m_par[8'(bad)]);
         end
         for (int i = 0; i < 6; i++)
            check("din_image", 32'(din_o[3'(i)]), 32'(m_din[3'(i)]));
         if (start_o) start_seen++;
      end
   end

   task automatic idle(input int n);
      s_valid_i = 1'b0;
      repeat (n) begin @(posedge clk_i); #1; end
   endtask

   task automatic send(input logic [7:0] b, input int gapmax);
      int g;
      g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      if (g > 0) idle(g);
      s_valid_i = 1'b1;
      s_data_i  = b;
      @(posedge clk_i); #1;
      s_valid_i = 1'b0;
   endtask

   task automatic send_params(input int mul, input int add, input int gapmax);
      send(8'h01, gapmax);
      for (int k = 0; k < 163; k++) send(8'((k * mul + add) & 255), gapmax);
   endtask

   task automatic send_din(input logic [7:0] base, input int gapmax);
      send(8'h02, gapmax);
      for (int i = 0; i < 6; i++) send(base + 8'(i), gapmax);
   endtask

   initial begin
      int s0;
      rst_i = 1'b1; clear_i = 1'b0; s_valid_i = 1'b0; s_data_i = 8'h00;
      #12;
      check("rst_w1", 32'(w1_o[0][0]), 32'h0);
      check("rst_b2", 32'(b2_o[2]), 32'h0);
      check("rst_flags", 32'({params_valid_o, din_valid_o, start_o, busy_o, err_o}), 32'h0);
      check("rst_ready", 32'(s_ready_o), 32'h1);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      // input frame with no parameters: valid but no start
      s0 = start_seen;
      send_din(8'h10, 0);
      idle(2);
      check("din_nopar_valid", 32'(din_valid_o), 32'h1);
      check("din_nopar_d0", 32'(din_o[0]), 32'h10);
      check("din_nopar_d5", 32'(din_o[5]), 32'h15);
      check("din_nopar_nostart", 32'(start_seen - s0), 32'h0);

      send_params(1, 1, 0);
      check("par_valid_next", 32'(params_valid_o), 32'h1);
      check("par_idle", 32'(busy_o), 32'h0);
      check("par_w1_00", 32'(w1_o[0][0]), 32'd1);
      check("par_w1_515", 32'(w1_o[5][15]), 32'd96);
      check("par_b1_0", 32'(b1_o[0]), 32'd97);
      check("par_w2_152", 32'(w2_o[15][2]), 32'd160);
      check("par_b2_2", 32'(b2_o[2]), 32'd163);

      s0 = start_seen;
      send_din(8'h10, 0);
      check("din_start_now", 32'(start_o), 32'h1);
      check("din_valid_now", 32'(din_valid_o), 32'h1);
      idle(3);
      check("din_start_once", 32'(start_seen - s0), 32'h1);
      check("din_d3", 32'(din_o[3]), 32'h13);

      send(8'h7F, 0);
      check("bad_err", 32'(err_o), 32'h1);
      check("bad_ready", 32'(s_ready_o), 32'h0);
      send(8'h01, 0); send(8'h02, 0); send(8'h01, 0);
      check("bad_stuck_err", 32'(err_o), 32'h1);
      check("bad_pv_kept", 32'(params_valid_o), 32'h1);
      clear_i = 1'b1;
      @(posedge clk_i); #1;
      clear_i = 1'b0;
      check("clr_err", 32'(err_o), 32'h0);
      check("clr_ready", 32'(s_ready_o), 32'h1);
      send_din(8'h20, 0);
      check("clr_din0", 32'(din_o[0]), 32'h20);
      check("clr_din5", 32'(din_o[5]), 32'h25);

      // abort a parameter frame after 50 bytes; the byte under clear is dropped
      send(8'h01, 0);
      for (int k = 0; k < 50; k++) send(8'((k + 8'h81) & 255), 0);
      clear_i = 1'b1; s_valid_i = 1'b1; s_data_i = 8'hEE;
      @(posedge clk_i); #1;
      clear_i = 1'b0; s_valid_i = 1'b0;
      idle(1);
      check("abort_pv", 32'(params_valid_o), 32'h0);
      check("abort_busy", 32'(busy_o), 32'h0);
      check("abort_w1_00", 32'(w1_o[0][0]), 32'h81);
      check("abort_w1_215", 32'(w1_o[2][15]), 32'hB0);
      check("abort_w1_31", 32'(w1_o[3][1]), 32'hB2);
      check("abort_w1_32_kept", 32'(w1_o[3][2]), 32'd51);
      send_params(1, 1, 0);
      check("reload_pv", 32'(params_valid_o), 32'h1);
      check("reload_w1_00", 32'(w1_o[0][0]), 32'd1);
      check("reload_b2_2", 32'(b2_o[2]), 32'd163);

      // stalled frames
      send_params(3, 7, 3);
      check("stall_pv", 32'(params_valid_o), 32'h1);
      check("stall_w1_00", 32'(w1_o[0][0]), 32'd7);
      check("stall_w2_00", 32'(w2_o[0][0]), 32'd87);
      check("stall_b2_2", 32'(b2_o[2]), 32'd237);
      s0 = start_seen;
      send_din(8'h40, 3);
      idle(2);
      check("stall_start_once", 32'(start_seen - s0), 32'h1);
      check("stall_din2", 32'(din_o[2]), 32'h42);

      // asynchronous reset mid input frame
      send(8'h02, 0); send(8'h55, 0); send(8'h56, 0);
      #3 rst_i = 1'b1;
      #1;
      check("arst_w1", 32'(w1_o[0][0]), 32'h0);
      check("arst_b2", 32'(b2_o[2]), 32'h0);
      check("arst_din", 32'(din_o[0]), 32'h0);
      check("arst_flags", 32'({params_valid_o, din_valid_o, start_o, busy_o, err_o}), 32'h0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check("arst_ready", 32'(s_ready_o), 32'h1);
      s0 = start_seen;
      send_din(8'h60, 0);
      idle(2);
      check("arst_din_valid", 32'(din_valid_o), 32'h1);
      check("arst_nostart", 32'(start_seen - s0), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
